// File: rtl/seq_pkg.sv
// Shared types and address tables for the program run sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        REPORT,
        FINISHED
    } seq_state_t;

    localparam int NUM_PROGS_MAX = 4;

    localparam int unsigned START_ADDR [NUM_PROGS_MAX] = '{66, 400, 700, 900};
    localparam int unsigned END_ADDR   [NUM_PROGS_MAX] = '{300, 650, 850, 1000};

    typedef struct packed {
        logic fetch_init;
        logic stall;
        logic busy;
        logic prog_done;
        logic all_done;
    } seq_out_t;

    // Control outputs are a pure function of the state being entered.
    function automatic seq_out_t state_outputs(input seq_state_t s);
        seq_out_t o;
        o = '0;
        o.fetch_init = 1'b1;
        case (s)
            LOAD: o.busy = 1'b1;
            RUN: begin
                o.fetch_init = 1'b0;
                o.busy       = 1'b1;
            end
            DRAIN: begin
                o.stall = 1'b1;
                o.busy  = 1'b1;
            end
            REPORT: begin
                o.stall     = 1'b1;
                o.busy      = 1'b1;
                o.prog_done = 1'b1;
            end
            FINISHED: begin
                o.stall    = 1'b1;
                o.all_done = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module seq_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Run controller stepping the fetch unit through the fixed program table.
// Optional watchdog abort per program is built in with SEQ_WATCHDOG_EN.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PROGS    = 3,
    parameter int PC_W         = 16,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int WDOG_LIMIT   = 100000
) (
    input  logic             CLK,
    input  logic             Init_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  PC,
    input  logic             Halt,
    output logic             Fetch_Init,
    output logic [PC_W-1:0]  Start_PC,
    output logic             Stall,
    output logic [1:0]       Prog_Sel,
    output logic             Busy,
    output logic             Prog_Done,
    output logic [CNT_W-1:0] Cycle_Count,
    output logic             All_Done,
    output logic             Timeout
);

`ifdef SEQ_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    seq_state_t state, state_nxt;
    seq_out_t   out_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] drain_cnt;
    logic       end_hit, wdog_hit, run_done, last_prog, drain_done, timeout_q;

    assign end_hit    = PC == PC_W'(END_ADDR[Prog_Sel]);
    assign wdog_hit   = WDOG_ON && (Cycle_Count == CNT_W'(WDOG_LIMIT));
    assign run_done   = Halt || end_hit || wdog_hit;
    assign last_prog  = Prog_Sel == 2'(NUM_PROGS - 1);
    assign drain_done = drain_cnt == 4'(DRAIN_CYCLES - 1);

    always_comb begin
        state_nxt = state;
        sel_nxt   = Prog_Sel;
        case (state)
            IDLE: if (Start) begin
                state_nxt = LOAD;
                sel_nxt   = '0;
            end
            LOAD:  state_nxt = RUN;
            RUN:   if (run_done) state_nxt = DRAIN;
            DRAIN: if (drain_done) state_nxt = REPORT;
            REPORT: begin
                if (last_prog) begin
                    state_nxt = FINISHED;
                end else begin
                    state_nxt = LOAD;
                    sel_nxt   = Prog_Sel + 2'd1;
                end
            end
            FINISHED: if (!Start) begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
        out_nxt = state_outputs(state_nxt);
    end

    // The watchdog cycle itself is not counted, so the abort reports exactly the limit.
    seq_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (CLK),
        .rst_n (Init_n),
        .clr   (state_nxt == LOAD),
        .en    (state == RUN && !wdog_hit),
        .count (Cycle_Count)
    );

    seq_sat_counter #(.W(4)) u_drain_cnt (
        .clk   (CLK),
        .rst_n (Init_n),
        .clr   (state == RUN),
        .en    (state == DRAIN),
        .count (drain_cnt)
    );

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state      <= IDLE;
            Prog_Sel   <= '0;
            Start_PC   <= PC_W'(START_ADDR[0]);
            Fetch_Init <= 1'b1;
            Stall      <= 1'b0;
            Busy       <= 1'b0;
            Prog_Done  <= 1'b0;
            All_Done   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            Prog_Sel   <= sel_nxt;
            Start_PC   <= PC_W'(START_ADDR[sel_nxt]);
            Fetch_Init <= out_nxt.fetch_init;
            Stall      <= out_nxt.stall;
            Busy       <= out_nxt.busy;
            Prog_Done  <= out_nxt.prog_done;
            All_Done   <= out_nxt.all_done;
            if (state_nxt == LOAD) begin
                timeout_q <= 1'b0;
            end else if (state == RUN && wdog_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign Timeout = timeout_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: program-position reference model plus directed and random stimulus.
module tb_prog_sequencer;

    localparam int NP   = 3;
    localparam int D    = 2;
    localparam int WDL  = 50;
`ifdef SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    int unsigned s_tab [4] = '{66, 400, 700, 900};
    int unsigned e_tab [4] = '{300, 650, 850, 1000};

    logic        CLK = 1'b0;
    logic        Init_n = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] PC = 16'd0;
    logic        Halt = 1'b0;
    logic        Fetch_Init, Stall, Busy, Prog_Done, All_Done, Timeout;
    logic [15:0] Start_PC;
    logic [1:0]  Prog_Sel;
    logic [31:0] Cycle_Count;

    prog_sequencer #(.NUM_PROGS(NP), .PC_W(16), .CNT_W(32), .DRAIN_CYCLES(D), .WDOG_LIMIT(WDL)) dut (
        .CLK(CLK), .Init_n(Init_n), .Start(Start), .PC(PC), .Halt(Halt),
        .Fetch_Init(Fetch_Init), .Start_PC(Start_PC), .Stall(Stall), .Prog_Sel(Prog_Sel),
        .Busy(Busy), .Prog_Done(Prog_Done), .Cycle_Count(Cycle_Count), .All_Done(All_Done),
        .Timeout(Timeout)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: position t within the current program (0 = load, 1..k = run, then drain, then report).
    bit          m_active = 0, m_fin = 0, m_tmo = 0;
    int          m_p = 0, m_t = 0, m_k = -1;
    longint      m_cnt = 0;

    always @(negedge CLK) begin
        logic e_fi, e_st, e_busy, e_pd, e_ad;
        bit   wd;
        if (!Init_n) begin
            m_active = 0; m_fin = 0; m_tmo = 0; m_p = 0; m_t = 0; m_k = -1; m_cnt = 0;
        end
        e_fi = 1; e_st = 0; e_busy = 0; e_pd = 0; e_ad = 0;
        if (m_active) begin
            e_busy = 1;
            if (m_t == 0) ;
            else if (m_k < 0 || m_t <= m_k) e_fi = 0;
            else if (m_t <= m_k + D) e_st = 1;
            else begin e_st = 1; e_pd = 1; end
        end else if (m_fin) begin
            e_st = 1; e_ad = 1;
        end
        chk("ctl{fi,stall,sel,busy,done,all,tmo}",
            64'({Fetch_Init, Stall, Prog_Sel, Busy, Prog_Done, All_Done, Timeout}),
            64'({e_fi, e_st, 2'(m_p), e_busy, e_pd, e_ad, m_tmo}));
        chk("start_pc", 64'(Start_PC), 64'(s_tab[m_p]));
        chk("cycle_count", 64'(Cycle_Count), 64'(m_cnt));
        if (Init_n) begin
            if (!m_active && !m_fin) begin
                if (Start) begin m_active = 1; m_p = 0; m_t = 0; m_k = -1; m_cnt = 0; m_tmo = 0; end
            end else if (m_fin) begin
                if (!Start) begin m_fin = 0; m_p = 0; end
            end else begin
                if (m_t >= 1 && m_k < 0) begin
                    wd = WD_ON && (m_cnt == WDL);
                    if (Halt || PC == 16'(e_tab[m_p]) || wd) begin
                        m_k = m_t;
                        if (wd) m_tmo = 1;
                    end
                    if (!wd && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end
                m_t++;
                if (m_k >= 0 && m_t == m_k + D + 2) begin
                    if (m_p == NP - 1) begin
                        m_active = 0; m_fin = 1;
                    end else begin
                        m_p++; m_t = 0; m_k = -1; m_cnt = 0; m_tmo = 0;
                    end
                end
            end
        end
    end

    // Stimulus: a tiny fetch unit plus halt/jump/start controls.
    bit hold_pc = 0, rand_jump = 0, rand_halt = 0, halt_at_end = 0;
    int halt_at = 0, run_idx = 0, n_steps = 0, pulses = 0;

    task automatic step(input bit start_v);
        logic        fi_c;
        logic [15:0] spc_c;
        fi_c  = Fetch_Init;
        spc_c = Start_PC;
        @(posedge CLK); #1;
        n_steps++;
        Start = start_v;
        if (fi_c) PC = spc_c;
        else if (hold_pc) PC = 16'd70;
        else if (rand_jump && $urandom_range(39) == 0) PC = 16'(e_tab[Prog_Sel] + $urandom_range(20)) - 16'd3;
        else PC = PC + 16'd1;
        run_idx = Fetch_Init ? 0 : run_idx + 1;
        Halt = (halt_at != 0 && run_idx == halt_at) ||
               (halt_at_end && !Fetch_Init && PC == 16'(e_tab[Prog_Sel])) ||
               (rand_halt && $urandom_range(63) == 0);
        if (Prog_Done) pulses++;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            step(1'b1);
            if (Prog_Done) begin seen = 1; break; end
        end
        chk(name, 64'(seen), 64'(1));
    endtask

    task automatic pulse_reset();
        step(Start);
        #2 Init_n = 1'b0;
        #1;
        chk("rst_fetch_init", 64'(Fetch_Init), 64'(1));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_prog_done", 64'(Prog_Done), 64'(0));
        chk("rst_cycle_count", 64'(Cycle_Count), 64'(0));
        chk("rst_sel_pc", 64'({Prog_Sel, Start_PC}), 64'({2'd0, 16'd66}));
        @(posedge CLK); #1 Init_n = 1'b1;
        run_idx = 0;
    endtask

    initial begin
        int end_step;
        bit s;
        #2 Init_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_vals", 64'({Fetch_Init, Stall, Busy, All_Done, Timeout, Start_PC}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd66}));
        Init_n = 1'b1;

        // Program 0 runs to its end address.
        step(1'b1);
        step(1'b1);
        chk("load_start_pc", 64'(Start_PC), 64'(66));
        chk("load_fetch_init", 64'(Fetch_Init), 64'(1));
        step(1'b1);
        chk("run_fetch_init", 64'(Fetch_Init), 64'(0));
        chk("run_first_pc", 64'(PC), 64'(66));
        end_step = -1;
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1);
            if (PC == 16'd300 && end_step < 0) end_step = n_steps;
            if (Prog_Done) break;
        end
        chk("p0_done", 64'(Prog_Done), 64'(1));
        chk("p0_latency", 64'(n_steps - end_step), 64'(3));
        chk("p0_count", 64'(Cycle_Count), 64'(235));

        // Program 1 halted at its 10th run cycle.
        halt_at = 10;
        wait_done("p1_done", 400);
        chk("p1_count_sel", 64'({Prog_Sel, Cycle_Count}), 64'({2'd1, 32'd10}));
        halt_at = 0;

        // Program 2: halt coincides with end address.
        halt_at_end = 1;
        wait_done("p2_done", 400);
        chk("p2_count_sel", 64'({Prog_Sel, Cycle_Count}), 64'({2'd2, 32'd151}));
        halt_at_end = 0;
        step(1'b1);
        chk("finished", 64'({All_Done, Busy}), 64'({1'b1, 1'b0}));
        repeat (4) step(1'b1);
        chk("no_autorestart", 64'({All_Done, Busy}), 64'({1'b1, 1'b0}));
        chk("pulse_count", 64'(pulses), 64'(3));
        step(1'b0);
        step(1'b0);
        chk("back_idle", 64'({All_Done, Prog_Sel}), 64'({1'b0, 2'd0}));

        // Asynchronous reset in the middle of a run.
        step(1'b1);
        repeat (30) step(1'b1);
        pulses = 0;
        pulse_reset();
        repeat (3) step(1'b0);
        chk("no_report_after_rst", 64'(pulses), 64'(0));

        // PC parked off the end address.
        hold_pc = 1;
        step(1'b1);
`ifdef SEQ_WATCHDOG_EN
        wait_done("wdog_done", 200);
        chk("wdog_timeout_count", 64'({Timeout, Cycle_Count}), 64'({1'b1, 32'd50}));
`else
        repeat (200) step(1'b1);
        chk("no_wdog_stuck", 64'({Fetch_Init, Busy, Timeout}), 64'({1'b0, 1'b1, 1'b0}));
`endif
        hold_pc = 0;
        pulse_reset();

        // Randomized run against the model.
        rand_halt = 1;
        rand_jump = 1;
        for (int i = 0; i < 15000; i++) begin
            s = ($urandom_range(15) != 0);
            if ($urandom_range(2999) == 0) pulse_reset();
            else step(s);
        end

        @(posedge CLK); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
